// File: rtl/sram_fifo_ctrl_64x144.sv
// 64x144 streaming FIFO controller for a single-port-backed two-port SRAM wrapper.
// Optional build macro SRAM_FIFO_BYPASS_EN: wbuf->obuf bypass when the RAM region is empty.
module sram_fifo_ctrl_64x144 (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [143:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [143:0] out_data,
    output logic [6:0]   fifo_cnt,
    output logic         ram_rceb,
    output logic [5:0]   ram_raddr,
    input  logic [143:0] ram_rdata,
    output logic         ram_wceb,
    output logic [5:0]   ram_waddr,
    output logic [143:0] ram_wdata
);
    typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} gnt_t;

    logic               wbuf_vld;
    logic [143:0]       wbuf;
    logic [5:0]         wr_ptr, rd_ptr;
    logic [6:0]         ram_cnt;
    logic [1:0][143:0]  obuf_mem;
    logic               obuf_wp, obuf_rp;
    logic [1:0]         obuf_cnt;
    logic               rd_pend;
    gnt_t               last_grant;
    logic [5:0]         raddr_q, waddr_q;
    logic [143:0]       wdata_q;

    logic push, pop, wreq, rreq, wgnt, rgnt, bypass, obuf_push;
    logic [143:0] obuf_din;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;
    assign wreq = wbuf_vld & ~ram_cnt[6];
    // Credit check counts the read in flight so obuf can never overflow.
    assign rreq = (ram_cnt != 7'd0) & (({1'b0, obuf_cnt} + {2'b0, rd_pend}) < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
    assign bypass = wbuf_vld & (ram_cnt == 7'd0) & ~rd_pend & (obuf_cnt != 2'd2);
`else
    assign bypass = 1'b0;
`endif

    // Ties go to the type not granted last.
    assign wgnt = wreq & ~bypass & (~rreq | (last_grant == GNT_READ));
    assign rgnt = rreq & ~wgnt;

    assign in_rdy    = ~wbuf_vld | wgnt | bypass;
    assign ram_wceb  = ~wgnt;
    assign ram_waddr = wgnt ? wr_ptr : waddr_q;
    assign ram_wdata = wgnt ? wbuf : wdata_q;
    assign ram_rceb  = ~rgnt;
    assign ram_raddr = rgnt ? rd_ptr : raddr_q;

    assign obuf_push = rd_pend | bypass;
    assign obuf_din  = rd_pend ? ram_rdata : wbuf;
    assign out_vld   = (obuf_cnt != 2'd0);
    assign out_data  = obuf_mem[obuf_rp];
    assign fifo_cnt  = {6'd0, wbuf_vld} + ram_cnt + {5'd0, obuf_cnt} + {6'd0, rd_pend};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_vld   <= 1'b0;
            wbuf       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            obuf_mem   <= '0;
            obuf_wp    <= 1'b0;
            obuf_rp    <= 1'b0;
            obuf_cnt   <= '0;
            rd_pend    <= 1'b0;
            last_grant <= GNT_READ;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            if (push) begin
                wbuf     <= in_data;
                wbuf_vld <= 1'b1;
            end else if (wgnt | bypass) begin
                wbuf_vld <= 1'b0;
            end

            if (wgnt) begin
                wr_ptr     <= wr_ptr + 6'd1;
                ram_cnt    <= ram_cnt + 7'd1;
                waddr_q    <= wr_ptr;
                wdata_q    <= wbuf;
                last_grant <= GNT_WRITE;
            end else if (rgnt) begin
                rd_ptr     <= rd_ptr + 6'd1;
                ram_cnt    <= ram_cnt - 7'd1;
                raddr_q    <= rd_ptr;
                last_grant <= GNT_READ;
            end
            rd_pend <= rgnt;

            if (obuf_push) begin
                obuf_mem[obuf_wp] <= obuf_din;
                obuf_wp           <= ~obuf_wp;
            end
            if (pop)
                obuf_rp <= ~obuf_rp;
            obuf_cnt <= obuf_cnt + {1'b0, obuf_push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl_64x144.sv
// Scoreboard bench for sram_fifo_ctrl_64x144 with a behavioural 64x144 RAM model.
module tb_sram_fifo_ctrl_64x144;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [143:0] in_data = '0;
    logic         out_vld;
    logic         out_rdy = 1'b0;
    logic [143:0] out_data;
    logic [6:0]   fifo_cnt;
    logic         ram_rceb, ram_wceb;
    logic [5:0]   ram_raddr, ram_waddr;
    logic [143:0] ram_rdata = '0;
    logic [143:0] ram_wdata;

`ifdef SRAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
    string gnt_exp = "--WWWW";
`else
    localparam int LAT = 3;
    string gnt_exp = "WRWRWW";
`endif

    int total = 0;
    int bad   = 0;
    logic [143:0] exp_q[$];
    logic [143:0] mem [64];
    logic [5:0]   exp_wa = '0, exp_ra = '0;
    logic         saw_wrap = 1'b0;
    logic         rec_on = 1'b0;
    int           rec_n = 0;
    logic [7:0]   rec [6];
    logic         stream_done;

    sram_fifo_ctrl_64x144 dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .fifo_cnt(fifo_cnt),
        .ram_rceb(ram_rceb), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_wceb(ram_wceb), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
        if (!ram_rceb) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_empty: got %h want none", out_data);
            end else
                chk("out_data", out_data, exp_q.pop_front());
        end
    end

    // RAM port monitor: mutual exclusion, address sequence, grant log.
    always @(negedge clk) begin
        if (rst) begin
            exp_wa = '0;
            exp_ra = '0;
        end else begin
            chk("port_excl", 144'(ram_rceb | ram_wceb), 144'd1);
            if (!ram_wceb) begin
                chk("waddr", 144'(ram_waddr), 144'(exp_wa));
                if (ram_waddr == 6'd63) saw_wrap = 1'b1;
                exp_wa = exp_wa + 6'd1;
            end
            if (!ram_rceb) begin
                chk("raddr", 144'(ram_raddr), 144'(exp_ra));
                exp_ra = exp_ra + 6'd1;
            end
            if (rec_on && rec_n < 6) begin
                rec[rec_n] = !ram_wceb ? 8'h57 : (!ram_rceb ? 8'h52 : 8'h2d);
                rec_n++;
            end
        end
    end

    task automatic push(input logic [143:0] d);
        int n = 0;
        in_vld  = 1'b1;
        in_data = d;
        forever begin
            @(negedge clk);
            if (in_rdy) begin
                exp_q.push_back(d);
                @(posedge clk); #1;
                in_vld = 1'b0;
                return;
            end
            n++;
            if (n > 300) begin
                total++; bad++;
                $display("FAIL push_timeout: got in_rdy=0 want 1 data=%h", d);
                in_vld = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        out_rdy = 1'b1;
        while (fifo_cnt != 7'd0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_cnt", 144'(fifo_cnt), 144'd0);
        chk("drain_q", 144'(exp_q.size()), 144'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_vld = 1'b0;
        out_rdy = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic latency_case(input logic [143:0] d, input string nm);
        int k = 0;
        push(d);
        chk({nm, "_cnt1"}, 144'(fifo_cnt), 144'd1);
        while (!out_vld && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_lat"}, 144'(k), 144'(LAT));
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk({nm, "_cnt0"}, 144'(fifo_cnt), 144'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_in_rdy", 144'(in_rdy), 144'd1);
        chk("rst_out_vld", 144'(out_vld), 144'd0);
        chk("rst_out_data", out_data, 144'd0);
        chk("rst_cnt", 144'(fifo_cnt), 144'd0);
        chk("rst_rceb", 144'(ram_rceb), 144'd1);
        chk("rst_wceb", 144'(ram_wceb), 144'd1);
        chk("rst_raddr", 144'(ram_raddr), 144'd0);
        chk("rst_waddr", 144'(ram_waddr), 144'd0);
        chk("rst_wdata", ram_wdata, 144'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single word, empty-FIFO latency
        latency_case({{17{8'h5A}}, 8'hA5}, "single");

        // Tie arbitration and fill to 67
        do_reset();
        push(144'd0);
        rec_on = 1'b1;
        for (int i = 1; i < 67; i++) push(144'(i));
        for (int i = 0; i < 6; i++)
            chk($sformatf("gnt%0d", i), 144'(rec[i]), 144'(gnt_exp[i]));
        in_vld  = 1'b1;
        in_data = 144'd67;
        repeat (4) begin
            @(negedge clk);
            chk("full_in_rdy", 144'(in_rdy), 144'd0);
        end
        chk("full_cnt", 144'(fifo_cnt), 144'd67);
        @(posedge clk); #1 in_vld = 1'b0;
        drain();
        out_rdy = 1'b0;

        // Random-stall stream of 1000 words
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    push({16'h1000, 128'(i)});
                    repeat ($urandom_range(0, 1)) @(posedge clk);
                    #1;
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        out_rdy = 1'b0;

        // Wrap with occupancy held near 10
        saw_wrap = 1'b0;
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) push({16'h2000, 128'(i)});
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_rdy = (fifo_cnt >= 7'd10);
                end
            end
        join
        drain();
        out_rdy = 1'b0;
        chk("wrap_seen", 144'(saw_wrap), 144'd1);

        // Reset mid-stream with 30 words held
        for (int i = 0; i < 30; i++) push({16'h3000, 128'(i)});
        chk("mid_cnt30", 144'(fifo_cnt), 144'd30);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_out_vld", 144'(out_vld), 144'd0);
        chk("mid_cnt", 144'(fifo_cnt), 144'd0);
        chk("mid_rceb", 144'(ram_rceb), 144'd1);
        chk("mid_wceb", 144'(ram_wceb), 144'd1);
        @(posedge clk); #1 rst = 1'b0;
        latency_case({16'h4000, 128'h1234_5678}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
